// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR stream controller:
//   - default sample width, input FIFO depth and watchdog limit
//   - sample typedef at the default width
//   - FSM state encoding used by fir_stream_ctrl
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef logic [DEF_WIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_HOLD_OUT  = 3'd3,
        ST_WAIT_LOW  = 3'd4
    } fir_state_e;

endpackage

// File: rtl/fir_sample_fifo.sv
// ---------------------------------------------------------------------------
// fir_sample_fifo
// Small first-word-fall-through sample FIFO with a registered head.
// The head register always holds the oldest entry, so a sample written into
// an empty FIFO is visible on rd_data_o in the following cycle.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-low reset (empties the FIFO)
//   wr_en_i    write request; ignored while full
//   wr_data_i  sample to write
//   rd_en_i    pop request; ignored while empty
//   rd_data_o  oldest entry (registered), valid while !empty_o
//   full_o     DEPTH entries stored
//   empty_o    no entries stored
// ---------------------------------------------------------------------------
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push;
    logic             pop;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign rd_data_o = head_q;

    always_comb begin
        push     = wr_en_i && !full_o;
        pop      = rd_en_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The next head is the slot at the next read pointer; when that slot
        // is being written this cycle the array still holds stale data, so
        // forward the incoming sample instead.
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fir_stream_ctrl
// Streams host samples through an external FIR engine one at a time:
// buffers input samples, launches the filter with a one-cycle start pulse,
// captures the result, holds it until the consumer accepts it, and guards
// each computation with a watchdog.
//
// Ports:
//   clock, reset                 system clock / synchronous active-low reset
//   in_valid, in_ready, in_data  host sample stream into the input FIFO
//   fir_start, fir_in_sample     launch pulse and operand to the filter
//   fir_done, fir_out_sample     filter completion level and result
//   out_valid, out_ready, out_data  filtered sample stream to the consumer
//   busy                         FSM not in IDLE
//   timeout_err                  sticky watchdog error
//   sample_count                 completed samples, wraps at 16 bits
// ---------------------------------------------------------------------------
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             fir_start,
    output logic [WIDTH-1:0] fir_in_sample,
    input  logic             fir_done,
    input  logic [WIDTH-1:0] fir_out_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             timeout_err,
    output logic [15:0]      sample_count
);

    // The fir_start cycle (ISSUE) is the first watchdog cycle, so the error
    // is raised on the WAIT_DONE cycle whose count is TIMEOUT-2; timeout_err
    // then rises exactly TIMEOUT cycles after fir_start.
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 2);

    fir_state_e       state_q;
    logic             fir_start_q;
    logic [WIDTH-1:0] fir_in_sample_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;
    logic             timeout_err_q;
    logic [15:0]      sample_count_q;
    logic [WDW-1:0]   watchdog_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             launch;

    // A new computation may only begin once the filter has dropped fir_done,
    // which also covers the case where reset released mid-computation.
    assign launch = (state_q == ST_IDLE) && !fifo_empty && !out_valid_q && !fir_done;

    fir_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (in_valid),
        .wr_data_i (in_data),
        .rd_en_i   (launch),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            fir_start_q     <= 1'b0;
            fir_in_sample_q <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
            sample_count_q  <= '0;
            watchdog_q      <= '0;
        end else begin
            fir_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        fir_in_sample_q <= fifo_head;
                        fir_start_q     <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    watchdog_q <= '0;
                    state_q    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (fir_done) begin
                        out_data_q     <= fir_out_sample;
                        out_valid_q    <= 1'b1;
                        sample_count_q <= sample_count_q + 16'd1;
                        state_q        <= ST_HOLD_OUT;
                    end else if (watchdog_q == WD_LIMIT) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_WAIT_LOW;
                    end else begin
                        watchdog_q <= watchdog_q + WDW'(1);
                    end
                end
                ST_HOLD_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!fir_done) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = !fifo_full;
    assign fir_start     = fir_start_q;
    assign fir_in_sample = fir_in_sample_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign sample_count  = sample_count_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_ctrl
// Directed bench: a behavioural filter model answers fir_start with
// (operand ^ key) after a programmable delay and hold time; expected outputs
// are queued when samples are sent and a monitor compares them on each
// accepted output.
// ---------------------------------------------------------------------------
module tb_fir_stream_ctrl;
    import fir_pkg::*;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] count;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic        in_ready;
    sample_t     in_data;
    logic        fir_start;
    sample_t     fir_in_sample;
    logic        fir_done;
    sample_t     fir_out_sample;
    logic        out_valid;
    logic        out_ready;
    sample_t     out_data;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sample_count;

    logic        model_done  = 1'b0;
    sample_t     model_data  = 16'h5A5A;
    logic        force_done  = 1'b0;
    logic        filt_enable = 1'b1;
    int          done_delay  = 1;
    int          done_hold   = 1;
    sample_t     key         = 16'hB9F9;

    int          n_vec     = 0;
    int          n_err     = 0;
    int          start_cnt = 0;
    logic [15:0] exp_count = 16'd0;
    exp_t        exp_q[$];

    assign fir_done       = model_done | force_done;
    assign fir_out_sample = model_data;

    fir_stream_ctrl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .fir_start      (fir_start),
        .fir_in_sample  (fir_in_sample),
        .fir_done       (fir_done),
        .fir_out_sample (fir_out_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .sample_count   (sample_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Filter model: launched by fir_start, replies after done_delay cycles.
    initial begin : filter_model
        sample_t r;
        forever begin
            @(negedge clock);
            if (reset && fir_start && filt_enable) begin
                r = fir_in_sample ^ key;
                repeat (done_delay) @(posedge clock);
                #1;
                model_done = 1'b1;
                model_data = r;
                repeat (done_hold) @(posedge clock);
                #1;
                model_done = 1'b0;
                model_data = 16'hDEAD;
            end
        end
    end

    // Monitor: start-pulse rules and scoreboard comparison of accepted outputs.
    initial begin : monitor
        logic prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (fir_start) begin
                    start_cnt++;
                    check("start_pulse", {30'd0, prev_start, fir_done}, 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out: got data 0x%04h, required no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("out  data=0x%04h count=%0d (exp 0x%04h/%0d)",
                                 out_data, sample_count, e.data, e.count);
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_count", 32'(sample_count), 32'(e.count));
                    end
                end
            end
            prev_start = reset ? fir_start : 1'b0;
        end
    end

    task automatic send(input sample_t d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        $display("in   data=0x%04h", d);
    endtask

    task automatic push_exp(input sample_t r);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.data  = r;
        e.count = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic send_exp(input sample_t d, input sample_t r);
        push_exp(r);
        send(d);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) tick();
        while ((busy || out_valid || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!fir_start && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(fir_start), 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_in_ready",      32'(in_ready),      32'd1);
        check("rst_fir_start",     32'(fir_start),     32'd0);
        check("rst_fir_in_sample", 32'(fir_in_sample), 32'd0);
        check("rst_out_valid",     32'(out_valid),     32'd0);
        check("rst_out_data",      32'(out_data),      32'd0);
        check("rst_busy",          32'(busy),          32'd0);
        check("rst_timeout_err",   32'(timeout_err),   32'd0);
        check("rst_sample_count",  32'(sample_count),  32'd0);
    endtask

    initial begin : guard
        #500000;
        $display("FAIL global_guard: got no completion, required finish within time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int s0;
        int n;
        logic [15:0] c0;
        sample_t vals [5];
        vals[0] = 16'h0001;
        vals[1] = 16'h8000;
        vals[2] = 16'hFFFF;
        vals[3] = 16'h7FFF;
        vals[4] = 16'h5555;

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Power-on reset
        reset = 1'b0;
        repeat (3) tick();
        check_reset_state();
        reset = 1'b1;
        tick();

        // Single sample, filter answers two cycles after start
        done_delay = 2;
        s0 = start_cnt;
        send_exp(16'h1234, 16'hABCD);
        wait_idle("single_idle");
        check("single_starts", 32'(start_cnt - s0), 32'd1);
        check("single_count", 32'(sample_count), 32'd1);

        // Minimum latency: start to out_valid is two cycles with a 1-cycle filter
        done_delay = 1;
        send_exp(16'h0F0F, 16'h0F0F ^ key);
        wait_start("lat_start");
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd2);
        wait_idle("lat_idle");

        // FIFO full: fir_done held high keeps the FSM in IDLE
        force_done = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            send_exp(vals[i], vals[i] ^ key);
            check("full_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        push_exp(vals[4] ^ key);
        in_valid = 1'b1;
        in_data  = vals[4];
        repeat (3) begin
            tick();
            check("full_held", 32'(in_ready), 32'd0);
        end
        force_done = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("fifth_after_pop", 32'(n), 32'd1);
        tick();
        in_valid = 1'b0;
        $display("in   data=0x%04h", vals[4]);
        wait_idle("full_idle");

        // Back-pressure: consumer stalls for 10 cycles
        out_ready = 1'b0;
        send_exp(16'hC3C3, 16'hC3C3 ^ key);
        send_exp(16'h3C3C, 16'h3C3C ^ key);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        s0 = start_cnt;
        repeat (10) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(16'hC3C3 ^ key));
        end
        check("bp_no_start", 32'(start_cnt - s0), 32'd0);
        out_ready = 1'b1;
        wait_idle("bp_idle");

        // Timeout: filter never answers
        filt_enable = 1'b0;
        c0 = sample_count;
        send(16'h2222);
        wait_start("to_start");
        n = 0;
        while (!timeout_err && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_count", 32'(sample_count), 32'(c0));
        wait_idle("to_idle");
        filt_enable = 1'b1;
        send_exp(16'h3333, 16'h3333 ^ key);
        wait_idle("to_next_idle");
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // Stretched done: held five cycles, one capture per start
        done_hold = 5;
        s0 = start_cnt;
        send_exp(16'h1111, 16'h1111 ^ key);
        send_exp(16'hEEEE, 16'hEEEE ^ key);
        wait_idle("stretch_idle");
        check("stretch_starts", 32'(start_cnt - s0), 32'd2);
        done_hold = 1;

        // Reset in WAIT_DONE
        filt_enable = 1'b0;
        send(16'h4444);
        wait_start("rst_start");
        repeat (2) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check_reset_state();
        reset = 1'b1;
        exp_count = 16'd0;
        filt_enable = 1'b1;
        send_exp(16'h6789, 16'h6789 ^ key);
        wait_idle("post_reset_idle");
        check("post_reset_count", 32'(sample_count), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 4: input FIFO entries; power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles from fir_start to fir_done before an error is flagged.
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  host offers a sample.
REQ-007 in_ready  output  1  FIFO can accept a sample (not full).
REQ-008 in_data  input  WIDTH  host sample, two's complement.
REQ-009 fir_start  output  1  one-cycle pulse that launches one filter computation.
REQ-010 fir_in_sample  output  WIDTH  sample presented to the filter.
REQ-011 fir_done  input  1  filter result valid; level, held at least 1 cycle.
REQ-012 fir_out_sample  input  WIDTH  filter result.
REQ-013 out_valid  output  1  filtered sample available.
REQ-014 out_ready  input  1  consumer accepts the sample.
REQ-015 out_data  output  WIDTH  filtered sample.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  sticky error flag.
REQ-018 sample_count  output  16  number of completed samples; wraps 0xFFFF to 0.

Function
REQ-019 Input FIFO: a write occurs when in_valid and in_ready are both high. A simultaneous read and write when full is not permitted, because in_ready is low when full. A simultaneous read and write when empty passes the data through in the next cycle.
REQ-020 FSM states: IDLE, ISSUE, WAIT_DONE, HOLD_OUT, WAIT_LOW.
REQ-021 IDLE -> ISSUE when the FIFO is not empty and out_valid is low. In that cycle the FIFO head is popped into fir_in_sample.
REQ-022 ISSUE: fir_start=1 for exactly one cycle, then go to WAIT_DONE. The watchdog counter is cleared.
REQ-023 fir_in_sample shall remain stable from ISSUE until WAIT_LOW exits.
REQ-024 WAIT_DONE: on the first cycle with fir_done=1, capture fir_out_sample into out_data, set out_valid=1, increment sample_count, and go to HOLD_OUT.
REQ-025 WAIT_DONE: the watchdog increments every cycle. When it reaches TIMEOUT without fir_done, set timeout_err=1, discard the sample (no output, no count), and go to WAIT_LOW.
REQ-026 HOLD_OUT: out_valid stays high with out_data stable until out_ready=1. On that cycle out_valid clears and the FSM goes to WAIT_LOW. out_ready arriving in the same cycle as capture is ignored; the earliest accept is the cycle after.
REQ-027 WAIT_LOW: wait until fir_done=0, then go to IDLE. fir_start shall never assert while fir_done=1.
REQ-028 A fir_done pulse seen in IDLE, ISSUE or WAIT_LOW is ignored and not counted.
REQ-029 Minimum latency: 3 cycles from the FIFO pop to out_valid, when fir_done returns one cycle after fir_start.
REQ-030 timeout_err clears only on reset. Processing continues after an error.
REQ-031 No arithmetic is applied to samples; data passes bit-exact.

Reset
REQ-032 When reset=0 at a clock edge, the following take the listed values:
- FSM = IDLE
- FIFO empty, in_ready=1
- fir_start=0
- fir_in_sample=0
- out_valid=0
- out_data=0
- busy=0
- timeout_err=0
- sample_count=0
- watchdog=0
REQ-033 Reset asserted mid-operation aborts the computation, discards any captured output and the FIFO contents, and blocks new starts until reset releases. The next fir_start waits until fir_done=0.

Structure
REQ-034 A shared package fir_pkg holds the FSM state encoding, the default WIDTH/DEPTH/TIMEOUT constants, and the sample typedef.
REQ-035 The input FIFO is a sub-module, fir_sample_fifo (WIDTH and DEPTH parameters, registered output, full/empty flags). The FSM, watchdog and output register stay at top level.

Verification
REQ-036 Single sample: write 0x1234; model filter returns 0xABCD 2 cycles after start → exactly one fir_start pulse, out_data=0xABCD, sample_count=1.
REQ-037 FIFO full: 5 back-to-back writes with fir_done held off → in_ready=0 after the 4th accepted write; the 5th is held and accepted after the first pop.
REQ-038 Back-pressure: out_ready=0 for 10 cycles → out_valid and out_data hold, no new fir_start until acceptance.
REQ-039 Timeout: fir_done never asserts → timeout_err=1 exactly TIMEOUT cycles after start, sample_count unchanged, next sample processed normally.
REQ-040 Stretched done: fir_done held high 5 cycles → one capture only, next fir_start only after fir_done falls.
REQ-041 Reset mid-WAIT_DONE: reset=0 for 1 cycle → all outputs at reset values; a subsequent sample completes with sample_count=1.
